// File: rtl/seq_gen_pkg.sv
// Shared state encoding for the serial pattern generator (also decoded from the detector's debug bus).
// Also provides the effective-length rule used by both the FSM and the shift register.
package seq_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_DONE  = 3'd2
    } state_t;

    // A length of 0 or one larger than the register means "use the full width".
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
        return ((len == 0) || (len > width)) ? width : len;
    endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in/serial-out shift register; load left-aligns pattern[len-1:0] to the MSB, 1-cycle update.
// No backpressure: load, reload and shift are single-cycle commands from the owning FSM.
module piso_shreg
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             reload,
    input  logic             shift,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             msb
);

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] aligned;
    int unsigned      shamt;

    always_comb begin
        shamt   = WIDTH - eff_len(32'(len), WIDTH);
        aligned = pattern << shamt;
    end

    // hold keeps the aligned frame so repetitions restart without re-reading the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
            hold <= '0;
        end else if (load) begin
            sreg <= aligned;
            hold <= aligned;
        end else if (reload) begin
            sreg <= hold;
        end else if (shift) begin
            sreg <= sreg << 1;
        end
    end

    assign msb = sreg[WIDTH-1];

endmodule

// File: rtl/seq_gen.sv
// Serial bit-pattern generator: start in IDLE sends len bits MSB-first on b, then a one-cycle done.
// Optional SEQ_GEN_REPEAT_EN adds a reps port for back-to-back repetitions; start outside IDLE is dropped.
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = $clog2(WIDTH + 1)
`ifdef SEQ_GEN_REPEAT_EN
    ,
    parameter int CNT_W = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
`ifdef SEQ_GEN_REPEAT_EN
    input  logic [CNT_W-1:0] reps,
`endif
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic [2:0]       debug
);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_m1;
    logic             load, reload, shift;
    logic             msb;
`ifdef SEQ_GEN_REPEAT_EN
    logic [LEN_W-1:0] len_m1_q, len_m1_d;
    logic [CNT_W-1:0] reps_q, reps_d;
`endif

    assign len_m1 = LEN_W'(eff_len(32'(len), WIDTH) - 1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        reload   = 1'b0;
        shift    = 1'b0;
`ifdef SEQ_GEN_REPEAT_EN
        len_m1_d = len_m1_q;
        reps_d   = reps_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SHIFT;
                    load     = 1'b1;
                    cnt_d    = len_m1;
`ifdef SEQ_GEN_REPEAT_EN
                    len_m1_d = len_m1;
                    reps_d   = reps;
`endif
                end
            end
            ST_SHIFT: begin
                if (cnt_q == '0) begin
`ifdef SEQ_GEN_REPEAT_EN
                    // Restart directly from the held frame so repetitions have no idle bit between them.
                    if (reps_q != '0) begin
                        reload = 1'b1;
                        cnt_d  = len_m1_q;
                        reps_d = reps_q - CNT_W'(1);
                    end else begin
                        state_d = ST_DONE;
                    end
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    shift = 1'b1;
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
`ifdef SEQ_GEN_REPEAT_EN
            len_m1_q <= '0;
            reps_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
`ifdef SEQ_GEN_REPEAT_EN
            len_m1_q <= len_m1_d;
            reps_q   <= reps_d;
`endif
        end
    end

    piso_shreg #(
        .WIDTH(WIDTH),
        .LEN_W(LEN_W)
    ) u_piso (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .reload (reload),
        .shift  (shift),
        .pattern(pattern),
        .len    (len),
        .msb    (msb)
    );

    assign busy  = (state_q == ST_SHIFT);
    assign b     = busy & msb;
    assign done  = (state_q == ST_DONE);
    assign debug = state_q;

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboarded bench for seq_gen: the driver predicts accepted frames from timing rules, a negedge monitor checks them.
module tb_seq_gen;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;
`ifdef SEQ_GEN_REPEAT_EN
    localparam bit REPEAT = 1'b1;
`else
    localparam bit REPEAT = 1'b0;
`endif

    typedef struct {
        int start_edge;
        int nbits;
    } frame_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
`ifdef SEQ_GEN_REPEAT_EN
    logic [3:0]       reps;
`endif
    logic             b, busy, done;
    logic [2:0]       debug;

    int     checks = 0;
    int     errors = 0;
    int     edge_cnt = 0;
    int     next_ok = 0;
    int     run_len = 0;
    bit     mon_en = 1'b0;
    logic   exp_bits[$];
    frame_t frames[$];

    seq_gen #(
        .WIDTH(WIDTH),
        .LEN_W(LEN_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .pattern(pattern),
        .len    (len),
`ifdef SEQ_GEN_REPEAT_EN
        .reps   (reps),
`endif
        .b      (b),
        .busy   (busy),
        .done   (done),
        .debug  (debug)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Drive one cycle; the reference model decides acceptance purely from the frame timing rules.
    task automatic drive(input logic s, input logic [7:0] p, input logic [3:0] l,
                         input logic [3:0] r, input logic rs);
        int e, eff, nrep;
        start   = s;
        pattern = p;
        len     = l;
`ifdef SEQ_GEN_REPEAT_EN
        reps    = r;
`endif
        rst     = rs;
        e = edge_cnt + 1;
        if (!rs && s && e >= next_ok) begin
            eff  = (l == 0 || int'(l) > WIDTH) ? WIDTH : int'(l);
            nrep = REPEAT ? int'(r) + 1 : 1;
            for (int k = 0; k < nrep; k++)
                for (int i = eff - 1; i >= 0; i--)
                    exp_bits.push_back(p[i]);
            frames.push_back('{start_edge: e, nbits: eff * nrep});
            next_ok = e + eff * nrep + 2;
        end
        @(posedge clk);
        if (rs) begin
            exp_bits.delete();
            frames.delete();
            run_len = 0;
            next_ok = e + 1;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 4'd0, 4'd0, 1'b0);
    endtask

    always @(negedge clk) begin
        logic   eb;
        frame_t f;
        if (mon_en) begin
            if (busy) begin
                if (run_len == 0) begin
                    if (frames.size() == 0) chk(1'b0, "unexpected_frame", 1, 0);
                    else chk(edge_cnt == frames[0].start_edge, "frame_start_edge",
                             edge_cnt, frames[0].start_edge);
                end
                if (exp_bits.size() == 0) begin
                    chk(1'b0, "unexpected_bit", int'(b), -1);
                end else begin
                    eb = exp_bits.pop_front();
                    chk(b === eb, "serial_bit", int'(b), int'(eb));
                end
                chk(debug == 3'd1, "debug_shift", int'(debug), 1);
                run_len++;
            end else begin
                chk(b === 1'b0, "b_not_busy", int'(b), 0);
                if (done) begin
                    chk(debug == 3'd2, "debug_done", int'(debug), 2);
                    if (frames.size() == 0) begin
                        chk(1'b0, "unexpected_done", 1, 0);
                    end else begin
                        f = frames.pop_front();
                        chk(edge_cnt == f.start_edge + f.nbits, "done_edge",
                            edge_cnt, f.start_edge + f.nbits);
                        chk(run_len == f.nbits, "frame_length", run_len, f.nbits);
                    end
                    run_len = 0;
                end else begin
                    chk(debug == 3'd0, "debug_idle", int'(debug), 0);
                    chk(run_len == 0, "frame_gap", run_len, 0);
                end
            end
        end
    end

    initial begin
        int st;
        drive(1'b0, 8'h00, 4'd0, 4'd0, 1'b1);
        drive(1'b1, 8'hFF, 4'd0, 4'd0, 1'b1);
        chk(b === 1'b0, "reset_b", int'(b), 0);
        chk(busy === 1'b0, "reset_busy", int'(busy), 0);
        chk(done === 1'b0, "reset_done", int'(done), 0);
        chk(debug === 3'd0, "reset_debug", int'(debug), 0);
        mon_en = 1'b1;

        // Full-width frame via len=0, then a short frame.
        drive(1'b1, 8'hA5, 4'd0, 4'd0, 1'b0);
        idle(12);
        drive(1'b1, 8'h0D, 4'd4, 4'd0, 1'b0);
        idle(8);

        // Start and pattern churn during SHIFT must not disturb the frame or queue another.
        drive(1'b1, 8'h3C, 4'd8, 4'd0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 8'hFF, 4'd2, 4'd1, 1'b0);
        idle(10);

        // Reset sampled on the edge ending the third bit.
        drive(1'b1, 8'hA5, 4'd8, 4'd0, 1'b0);
        idle(2);
        drive(1'b0, 8'h00, 4'd0, 4'd0, 1'b1);
        idle(6);

        // Held start: back-to-back frames separated by DONE and IDLE.
        for (int i = 0; i < 20; i++) drive(1'b1, 8'h05, 4'd3, 4'd0, 1'b0);
        idle(6);

        // Repetitions (a plain single frame when repeat support is compiled out); len=1 edge case.
        drive(1'b1, 8'h05, 4'd3, 4'd2, 1'b0);
        idle(14);
        drive(1'b1, 8'h01, 4'd1, 4'd0, 1'b0);
        idle(4);
        drive(1'b1, 8'h6B, 4'd12, 4'd0, 1'b0);
        idle(12);

        for (int i = 0; i < 600; i++) begin
            st = int'($urandom_range(0, 99));
            drive(st < 35, 8'($urandom), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 3)), st == 99);
        end
        idle(40);

        chk(exp_bits.size() == 0, "bits_outstanding", exp_bits.size(), 0);
        chk(frames.size() == 0, "frames_outstanding", frames.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
